// File: rtl/sync_frame_tx.sv
// Serial frame transmitter: sync header, MSB-first payload, then an idle gap, one bit per clock.
// The line output j is registered and drives the sequence-detector input directly.
module sync_frame_tx #(
    parameter int unsigned          DATA_W   = 8,
    parameter int unsigned          SYNC_W   = 5,
    parameter logic [SYNC_W-1:0]    SYNC_PAT = 5'b10010,
    parameter int unsigned          GAP_LEN  = 2,
    parameter logic                 IDLE_BIT = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] data,
    output logic              j,
    output logic              ready,
    output logic              busy,
    output logic              done
);

    localparam int unsigned FRAME_W = SYNC_W + DATA_W;
    localparam int unsigned MAX_LEN = (SYNC_W > DATA_W)
                                      ? ((SYNC_W > GAP_LEN) ? SYNC_W : GAP_LEN)
                                      : ((DATA_W > GAP_LEN) ? DATA_W : GAP_LEN);
    localparam int unsigned CNT_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    localparam logic [CNT_W-1:0] SYNC_LOAD = CNT_W'(SYNC_W - 1);
    localparam logic [CNT_W-1:0] DATA_LOAD = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = (GAP_LEN > 0) ? CNT_W'(GAP_LEN - 1) : '0;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StSync = 2'd1;
    localparam logic [1:0] StData = 2'd2;
    localparam logic [1:0] StGap  = 2'd3;

    logic [1:0]         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    // Header and payload share one shift register; the MSB is always the next line bit.
    logic [FRAME_W-1:0] sreg_q, sreg_d;
    logic               j_q, j_d;
    logic               done_q, done_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sreg_d  = sreg_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StSync;
                    cnt_d   = SYNC_LOAD;
                    sreg_d  = {SYNC_PAT, data};
                end
            end
            StSync: begin
                sreg_d = {sreg_q[FRAME_W-2:0], 1'b0};
                if (cnt_q == '0) begin
                    state_d = StData;
                    cnt_d   = DATA_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            StData: begin
                sreg_d = {sreg_q[FRAME_W-2:0], 1'b0};
                if (cnt_q == '0) begin
                    if (GAP_LEN > 0) begin
                        state_d = StGap;
                        cnt_d   = GAP_LOAD;
                    end else begin
                        state_d = StIdle;
                        cnt_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            StGap: begin
                if (cnt_q == '0) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase

        // Line bit is derived from the next state so it appears in step with busy.
        j_d    = ((state_d == StSync) || (state_d == StData)) ? sreg_d[FRAME_W-1] : IDLE_BIT;
        done_d = (state_q != StIdle) && (state_d == StIdle);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            sreg_q  <= '0;
            j_q     <= IDLE_BIT;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sreg_q  <= sreg_d;
            j_q     <= j_d;
            done_q  <= done_d;
        end
    end

    assign j     = j_q;
    assign ready = (state_q == StIdle);
    assign busy  = (state_q != StIdle);
    assign done  = done_q;

endmodule

// File: tb/tb_sync_frame_tx.sv
// Directed bench for sync_frame_tx with default parameters and a 10010 Moore detector model.
module tb_sync_frame_tx;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] data;
    logic       j;
    logic       ready;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    sync_frame_tx dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .data  (data),
        .j     (j),
        .ready (ready),
        .busy  (busy),
        .done  (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Downstream 10010 Moore detector: output is a function of the last five registered bits.
    logic [4:0] hist;
    logic       det;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) hist <= 5'b0;
        else      hist <= {hist[3:0], j};
    end
    assign det = (hist == 5'b10010);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".j"},     32'(j),     32'd0);
        check({tag, ".ready"}, 32'(ready), 32'd1);
        check({tag, ".busy"},  32'(busy),  32'd0);
        check({tag, ".done"},  32'(done),  32'd0);
    endtask

    // Sends one frame from idle and checks every line bit, busy and the done pulse.
    task automatic send_frame(input logic [7:0] d, input bit poke, input bit chk_det);
        logic [14:0] exp;
        int det_cnt;
        int det_at;
        exp     = {5'b10010, d, 2'b00};
        det_cnt = 0;
        det_at  = 0;
        start   = 1'b1;
        data    = d;
        step();
        start = 1'b0;
        data  = ~d;
        for (int k = 1; k <= 15; k++) begin
            check("frame.j",     32'(j),     32'(exp[15-k]));
            check("frame.busy",  32'(busy),  32'd1);
            check("frame.ready", 32'(ready), 32'd0);
            check("frame.done",  32'(done),  32'd0);
            if (k <= 12 && det) begin
                det_cnt++;
                det_at = k;
            end
            if (poke && k == 4) begin
                start = 1'b1;
                data  = 8'h00;
            end
            if (poke && k == 5) start = 1'b0;
            step();
        end
        check("end.done",  32'(done),  32'd1);
        check("end.ready", 32'(ready), 32'd1);
        check("end.busy",  32'(busy),  32'd0);
        check("end.j",     32'(j),     32'd0);
        if (chk_det) begin
            check("det.count", 32'(det_cnt), 32'd1);
            check("det.cycle", 32'(det_at),  32'd6);
        end
        for (int k = 0; k < 4; k++) begin
            step();
            check_idle("after");
        end
    endtask

    initial begin
        logic [14:0] ff_bits;
        rst   = 1'b0;
        start = 1'b0;
        data  = 8'h00;
        #12;
        check_idle("rst");
        step();
        rst = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            check_idle("idle");
        end

        // Single A5 frame plus detector alignment.
        send_frame(8'hA5, 1'b0, 1'b1);

        // Back-to-back FF frames with start held high.
        ff_bits = {5'b10010, 8'hFF, 2'b00};
        start = 1'b1;
        data  = 8'hFF;
        step();
        for (int c = 1; c <= 32; c++) begin
            int pos;
            pos = (c - 1) % 16;
            if (pos < 15) begin
                check("b2b.j",    32'(j),    32'(ff_bits[14-pos]));
                check("b2b.busy", 32'(busy), 32'd1);
                check("b2b.done", 32'(done), 32'd0);
            end else begin
                check("b2b.j",     32'(j),     32'd0);
                check("b2b.busy",  32'(busy),  32'd0);
                check("b2b.done",  32'(done),  32'd1);
                check("b2b.ready", 32'(ready), 32'd1);
            end
            if (c == 31) start = 1'b0;
            step();
        end
        check_idle("b2b.stop");
        step();
        check_idle("b2b.stop2");

        // Start pulsed mid-frame is ignored.
        send_frame(8'hA5, 1'b1, 1'b0);

        // Asynchronous reset during the third payload bit.
        start = 1'b1;
        data  = 8'hA5;
        step();
        start = 1'b0;
        for (int k = 0; k < 7; k++) step();
        check("abort.j_before",    32'(j),    32'd1);
        check("abort.busy_before", 32'(busy), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check_idle("abort.async");
        step();
        check_idle("abort.held");
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check_idle("abort.released");
        end
        send_frame(8'h3C, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
